// File: rtl/alu_scoreboard.sv
// alu_scoreboard: on-chip response checker for the alu block.
// Pairs observed ALU responses with expected words over a fixed five-phase
// run (add, sub, and, or, not), keeps saturating per-op and per-flag match
// counters and reports a pass/fail verdict.
// Optional feature: define SCB_MISMATCH_LOG_EN to add a first-mismatch log
// (miss_valid, miss_idx, miss_word).
module alu_scoreboard #(
  parameter int unsigned VECS_PER_OP = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             obs_valid,
  input  logic [2:0]       obs_sel,
  input  logic [31:0]      obs_res,
  input  logic             obs_z,
  input  logic             obs_c,
  input  logic             obs_v,
  output logic             obs_ready,
  input  logic             exp_valid,
  input  logic [43:0]      exp_word,
  output logic             exp_ready,
  input  logic [2:0]       rd_idx,
  output logic [CNT_W-1:0] rd_cnt,
  output logic             busy,
  output logic             done,
  output logic             all_pass,
  output logic             seq_err
`ifdef SCB_MISMATCH_LOG_EN
  ,
  output logic             miss_valid,
  output logic [CNT_W-1:0] miss_idx,
  output logic [43:0]      miss_word
`endif
);

  localparam int unsigned NUM_OPS = 5;
  localparam int unsigned TOTAL   = NUM_OPS * VECS_PER_OP;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic             accept;
  logic             clear;
  logic             last_pair;
  logic [2:0]       op_idx;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] vec_cnt;
  logic             sel_ok, res_ok, z_ok, c_ok, v_ok;
  logic             s1_valid;
  logic [2:0]       s1_op;
  logic             s1_op_hit, s1_z_hit, s1_c_hit, s1_v_hit;
  logic [CNT_W-1:0] op_cnt [NUM_OPS];
  logic [CNT_W-1:0] z_cnt, c_cnt, v_cnt;
  logic [CNT_W-1:0] rd_sel;
  logic             pass_ok;
  logic             unused_pad;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x, input logic en);
    return (en && (x != '1)) ? x + CNT_W'(1) : x;
  endfunction

  // Pairing handshake: both sides consumed together, only while running
  assign accept    = (state == RUN) & obs_valid & exp_valid;
  assign obs_ready = accept;
  assign exp_ready = accept;
  assign clear     = start & ((state == IDLE) | (state == DONE));
  assign last_pair = (vec_cnt == CNT_W'(TOTAL - 1));

  // Pad bits of the expected word carry no information
  assign unused_pad = ^{exp_word[11:9], exp_word[7:5], exp_word[3:1]};

  // Per-pair compare against the expected word and the expected select
  always_comb begin
    sel_ok = (obs_sel == op_idx);
    res_ok = (obs_res == exp_word[43:12]);
    z_ok   = (obs_z == exp_word[8]);
    c_ok   = (obs_c == exp_word[4]);
    v_ok   = (obs_v == exp_word[0]);
  end

  // Control FSM with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      all_pass <= 1'b0;
    end else begin
      done     <= (state == DONE) && !start;
      all_pass <= (state == DONE) && !start && pass_ok;
      case (state)
        IDLE:    if (start) begin state <= RUN; busy <= 1'b1; end
        RUN:     if (accept && last_pair) state <= DRAIN;
        DRAIN:   begin state <= DONE; busy <= 1'b0; end
        DONE:    if (start) begin state <= RUN; busy <= 1'b1; end
        default: begin state <= IDLE; busy <= 1'b0; end
      endcase
    end
  end

  // Stage 1: register compare results and advance the pair/phase position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt   <= '0;
      phase_cnt <= '0;
      op_idx    <= '0;
      seq_err   <= 1'b0;
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_op_hit <= 1'b0;
      s1_z_hit  <= 1'b0;
      s1_c_hit  <= 1'b0;
      s1_v_hit  <= 1'b0;
    end else if (clear) begin
      vec_cnt   <= '0;
      phase_cnt <= '0;
      op_idx    <= '0;
      seq_err   <= 1'b0;
      s1_valid  <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_op     <= op_idx;
        s1_op_hit <= res_ok & sel_ok;
        s1_z_hit  <= z_ok;
        s1_c_hit  <= c_ok;
        s1_v_hit  <= v_ok;
        vec_cnt   <= vec_cnt + CNT_W'(1);
        if (phase_cnt == CNT_W'(VECS_PER_OP - 1)) begin
          phase_cnt <= '0;
          op_idx    <= op_idx + 3'd1;
        end else begin
          phase_cnt <= phase_cnt + CNT_W'(1);
        end
        if (!sel_ok) seq_err <= 1'b1;
      end
    end
  end

  // Stage 2: saturating match counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_OPS; i++) op_cnt[i] <= '0;
      z_cnt <= '0;
      c_cnt <= '0;
      v_cnt <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < NUM_OPS; i++) op_cnt[i] <= '0;
      z_cnt <= '0;
      c_cnt <= '0;
      v_cnt <= '0;
    end else if (s1_valid) begin
      for (int unsigned i = 0; i < NUM_OPS; i++)
        if (s1_op == 3'(i)) op_cnt[i] <= sat_inc(op_cnt[i], s1_op_hit);
      z_cnt <= sat_inc(z_cnt, s1_z_hit);
      c_cnt <= sat_inc(c_cnt, s1_c_hit);
      v_cnt <= sat_inc(v_cnt, s1_v_hit);
    end
  end

  // Verdict from final counter values
  always_comb begin
    pass_ok = !seq_err && (z_cnt == CNT_W'(TOTAL)) && (c_cnt == CNT_W'(TOTAL)) &&
              (v_cnt == CNT_W'(TOTAL));
    for (int unsigned i = 0; i < NUM_OPS; i++)
      if (op_cnt[i] != CNT_W'(VECS_PER_OP)) pass_ok = 1'b0;
  end

  // Counter read mux
  always_comb begin
    rd_sel = v_cnt;
    case (rd_idx)
      3'd0:    rd_sel = op_cnt[0];
      3'd1:    rd_sel = op_cnt[1];
      3'd2:    rd_sel = op_cnt[2];
      3'd3:    rd_sel = op_cnt[3];
      3'd4:    rd_sel = op_cnt[4];
      3'd5:    rd_sel = z_cnt;
      3'd6:    rd_sel = c_cnt;
      default: rd_sel = v_cnt;
    endcase
  end

  // Registered counter readback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_cnt <= '0;
    else        rd_cnt <= rd_sel;
  end

`ifdef SCB_MISMATCH_LOG_EN
  // First-mismatch capture; later mismatches leave the log untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_valid <= 1'b0;
      miss_idx   <= '0;
      miss_word  <= '0;
    end else if (clear) begin
      miss_valid <= 1'b0;
      miss_idx   <= '0;
      miss_word  <= '0;
    end else if (accept && !miss_valid && !(res_ok && sel_ok && z_ok && c_ok && v_ok)) begin
      miss_valid <= 1'b1;
      miss_idx   <= vec_cnt;
      miss_word  <= {obs_res, 3'd0, obs_z, 3'd0, obs_c, 3'd0, obs_v};
    end
  end
`endif

endmodule

// File: tb/tb_alu_scoreboard.sv
// tb_alu_scoreboard: self-checking bench for alu_scoreboard.
// Each presented pair pushes its expected outcome to a queue; entries are
// popped when the DUT consumes the pair and folded into reference counters.
module tb_alu_scoreboard;

  localparam int VPO   = 15;
  localparam int TOTAL = 5 * VPO;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        obs_valid = 1'b0;
  logic [2:0]  obs_sel = '0;
  logic [31:0] obs_res = '0;
  logic        obs_z = 1'b0, obs_c = 1'b0, obs_v = 1'b0;
  logic        obs_ready;
  logic        exp_valid = 1'b0;
  logic [43:0] exp_word = '0;
  logic        exp_ready;
  logic [2:0]  rd_idx = '0;
  logic [7:0]  rd_cnt;
  logic        busy, done, all_pass, seq_err;
`ifdef SCB_MISMATCH_LOG_EN
  logic        miss_valid;
  logic [7:0]  miss_idx;
  logic [43:0] miss_word;
`endif

  alu_scoreboard #(.VECS_PER_OP(VPO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .obs_valid(obs_valid), .obs_sel(obs_sel), .obs_res(obs_res),
    .obs_z(obs_z), .obs_c(obs_c), .obs_v(obs_v), .obs_ready(obs_ready),
    .exp_valid(exp_valid), .exp_word(exp_word), .exp_ready(exp_ready),
    .rd_idx(rd_idx), .rd_cnt(rd_cnt),
    .busy(busy), .done(done), .all_pass(all_pass), .seq_err(seq_err)
`ifdef SCB_MISMATCH_LOG_EN
    , .miss_valid(miss_valid), .miss_idx(miss_idx), .miss_word(miss_word)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    int          op;
    bit          res_eq;
    bit          sel_bad;
    bit          z_eq, c_eq, v_eq;
    logic [43:0] obs_word;
  } pair_t;

  pair_t       q[$];
  int          total = 0;
  int          bad = 0;
  int          m_cnt[8];
  bit          m_seq;
  bit          m_miss;
  int          m_miss_idx;
  logic [43:0] m_miss_word;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_seq = 1'b0;
    m_miss = 1'b0;
    m_miss_idx = 0;
    m_miss_word = '0;
    q.delete();
  endtask

  task automatic model_update(input pair_t p);
    if (p.res_eq && !p.sel_bad) m_cnt[p.op]++;
    if (p.z_eq) m_cnt[5]++;
    if (p.c_eq) m_cnt[6]++;
    if (p.v_eq) m_cnt[7]++;
    if (p.sel_bad) m_seq = 1'b1;
    if (!m_miss && !(p.res_eq && !p.sel_bad && p.z_eq && p.c_eq && p.v_eq)) begin
      m_miss = 1'b1;
      m_miss_idx = p.k;
      m_miss_word = p.obs_word;
    end
  endtask

  // Drive pair k with the mode's fault injected and return its expected outcome
  task automatic build_pair(input int k, input int mode, output pair_t p);
    logic [31:0] r;
    logic        z, c, v;
    int          op;
    op = k / VPO;
    r = $urandom;
    if (k % 7 == 3) r = '0;
    z = 1'($urandom);
    c = 1'($urandom);
    v = 1'($urandom);
    exp_word = {r, 3'd0, z, 3'd0, c, 3'd0, v};
    obs_res = r;
    obs_sel = 3'(op);
    obs_z = z;
    obs_c = c;
    obs_v = v;
    if (mode == 1 && k == 20) obs_res = r + 32'd1;
    if (mode == 2 && op == 0) obs_c = ~c;
    if (mode == 3 && k == 31) obs_sel = 3'd3;
    p.k = k;
    p.op = op;
    p.res_eq = (obs_res == r);
    p.sel_bad = (obs_sel != 3'(op));
    p.z_eq = (obs_z == z);
    p.c_eq = (obs_c == c);
    p.v_eq = (obs_v == v);
    p.obs_word = {obs_res, 3'd0, obs_z, 3'd0, obs_c, 3'd0, obs_v};
  endtask

  task automatic pulse_start();
    model_clear();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("done_after_start", done, 1'b0);
  endtask

  // Present pairs until stop_at have been consumed (bounded by a cycle budget)
  task automatic run_vectors(input int mode, input int stop_at);
    pair_t p;
    int    k = 0;
    int    cyc = 0;
    int    gaps = 0;
    bit    gap;
    while (k < stop_at && cyc < 400) begin
      gap = (mode == 4 && k == 10 && gaps < 3);
      if (gap) begin
        gaps++;
        obs_valid = 1'b1;
        exp_valid = 1'b0;
      end else begin
        if (q.size() == 0) begin
          build_pair(k, mode, p);
          q.push_back(p);
        end
        obs_valid = 1'b1;
        exp_valid = 1'b1;
      end
      start = (mode == 4 && k == 50);
      @(negedge clk);
      if (mode == 3 && k == 31) chk("seq_err_before", seq_err, 1'b0);
      if (mode == 3 && k == 32) chk("seq_err_edge", seq_err, 1'b1);
      chk("ready", {obs_ready, exp_ready}, {2{!gap}});
      if (obs_ready) begin
        if (q.size() == 0) chk("spurious_accept", 1'b1, 1'b0);
        else begin
          model_update(q.pop_front());
          k++;
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    if (cyc >= 400) chk("run_timeout", 1'b1, 1'b0);
    obs_valid = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic read_counters(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      @(posedge clk); #1;
      chk($sformatf("%s_cnt%0d", tag, i), rd_cnt, m_cnt[i]);
    end
  endtask

  task automatic finish_run(input string tag);
    bit want_pass;
    chk({tag, "_drain_busy"}, busy, 1'b1);
    chk({tag, "_drain_done"}, done, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_edge1_done"}, done, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_edge2_done"}, done, 1'b1);
    chk({tag, "_edge2_busy"}, busy, 1'b0);
    read_counters(tag);
    want_pass = !m_seq && m_cnt[5] == TOTAL && m_cnt[6] == TOTAL && m_cnt[7] == TOTAL;
    for (int i = 0; i < 5; i++) if (m_cnt[i] != VPO) want_pass = 1'b0;
    chk({tag, "_all_pass"}, all_pass, want_pass);
    chk({tag, "_seq_err"}, seq_err, m_seq);
`ifdef SCB_MISMATCH_LOG_EN
    chk({tag, "_miss_valid"}, miss_valid, m_miss);
    if (m_miss) begin
      chk({tag, "_miss_idx"}, miss_idx, m_miss_idx);
      chk({tag, "_miss_word"}, miss_word, m_miss_word);
    end
`endif
  endtask

  initial begin
    // Reset with random inputs
    model_clear();
    for (int i = 0; i < 3; i++) begin
      obs_valid = 1'($urandom);
      exp_valid = 1'($urandom);
      start = 1'($urandom);
      obs_res = $urandom;
      rd_idx = 3'($urandom);
      @(posedge clk); #1;
    end
    chk("rst_ready", {obs_ready, exp_ready}, 2'b00);
    chk("rst_rd_cnt", rd_cnt, 8'd0);
    chk("rst_status", {busy, done, all_pass, seq_err}, 4'b0000);
`ifdef SCB_MISMATCH_LOG_EN
    chk("rst_miss", {miss_valid, miss_idx, miss_word}, '0);
`endif
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    obs_valid = 1'b1;
    exp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ready", {obs_ready, exp_ready}, 2'b00);
    end
    obs_valid = 1'b0;
    exp_valid = 1'b0;

    pulse_start(); run_vectors(0, TOTAL); finish_run("clean");
    pulse_start(); run_vectors(1, TOTAL); finish_run("resmiss");
    pulse_start(); run_vectors(2, TOTAL); finish_run("flagmiss");
    pulse_start(); run_vectors(3, TOTAL); finish_run("order");
    pulse_start(); run_vectors(4, TOTAL); finish_run("bpress");

    // Abort by reset in the middle of the and phase
    pulse_start();
    run_vectors(0, 40);
    obs_valid = 1'b1;
    exp_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {obs_ready, exp_ready}, 2'b00);
    chk("abort_status", {busy, done, all_pass, seq_err}, 4'b0000);
    chk("abort_rd_cnt", rd_cnt, 8'd0);
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    obs_valid = 1'b0;
    exp_valid = 1'b0;
    model_clear();
    read_counters("abort");
    chk("abort_idle_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_scoreboard.md
# alu_scoreboard

Synthesizable response checker for the `alu` block, sitting at the far end of the ALU vector interface. It consumes the observed ALU outputs `{sel,res,z,c,v}` alongside packed 44-bit expected-response words, in lock-step pairs. It keeps per-operation and per-flag match counters across a fixed five-phase vector run (add, sub, and, or, not) and reports a pass/fail verdict, so ALU regression can run on-chip or on an emulator without a host-side bench.

## Interface
- `VECS_PER_OP`, 15, vectors per operation phase; total run length is TOTAL = 5*VECS_PER_OP pairs.
- `CNT_W`, 8, counter width; must satisfy 2^CNT_W-1 >= TOTAL.
- `clk` input 1, single clock, rising edge.
- `rst_n` input 1, reset, asynchronous, active-low.
- `start` input 1, one-cycle pulse that begins a run.
- `obs_valid` input 1, observed ALU response present.
- `obs_sel` input 3, ALU select used for this response.
- `obs_res` input 32, ALU result.
- `obs_z`, `obs_c`, `obs_v` input 1 each, ALU zero, carry and overflow flags.
- `obs_ready` output 1, observed response consumed this cycle.
- `exp_valid` input 1, expected word present.
- `exp_word` input 44, packed expected response `{res[31:0],3'd0,z,3'd0,c,3'd0,v}`; z is bit 8, c is bit 4, v is bit 0.
- `exp_ready` output 1, expected word consumed this cycle.
- `rd_idx` input 3, counter select: 0 add, 1 sub, 2 and, 3 or, 4 not, 5 z, 6 c, 7 v.
- `rd_cnt` output CNT_W, selected counter, registered.
- `busy` output 1, high in RUN and DRAIN.
- `done` output 1, high in DONE.
- `all_pass` output 1, valid while `done` is high.
- `seq_err` output 1, sticky select-order error.

## Operation
- FSM states:
  - IDLE: `start` goes to RUN.
  - RUN: the TOTAL-th accepted pair goes to DRAIN.
  - DRAIN: after one cycle, goes to DONE.
  - DONE: `start` goes to RUN.
- `start` in RUN or DRAIN is ignored.
- `start` from IDLE or DONE clears all counters, `vec_cnt`, `seq_err` and the log.
- Pairing:
  - `obs_ready = exp_ready = (state==RUN) & obs_valid & exp_valid`.
  - A pair is accepted only when both sides are valid; a lone valid side is never consumed.
  - Producers must not make valid depend on ready.
- Expected select for accepted pair k (0-based) is `k / VECS_PER_OP`, giving 0..4.
- Per accepted pair:
  - If `obs_sel` differs from the expected select, set `seq_err`.
  - Increment the op counter of the expected select iff `obs_res==exp_word[43:12]` and `obs_sel` matches.
  - Increment z iff `obs_z==exp_word[8]`.
  - Increment c iff `obs_c==exp_word[4]`.
  - Increment v iff `obs_v==exp_word[0]`.
  - Flag counters ignore select correctness.
- All counters saturate at 2^CNT_W-1.
- `all_pass` = every op counter == VECS_PER_OP, every flag counter == TOTAL, and `seq_err`==0. Held until the next `start`.
- `rd_cnt` is readable in any state.

## Timing
- Stage 1: at the acceptance edge N, the compare results and `vec_cnt` are registered.
- Stage 2: counters update at edge N+1.
- Back-to-back acceptance is allowed every cycle.
- DRAIN exists so the last pair's stage-2 update lands before DONE. `done` rises two edges after the final acceptance edge.
- `rd_cnt` updates one cycle after `rd_idx` changes or after the counter changes.
- Reset values:
  - State is IDLE.
  - All counters, `vec_cnt`, `rd_cnt`, `busy`, `done`, `all_pass` and `seq_err` are 0.
  - `obs_ready` and `exp_ready` are 0.
- `rst_n` low mid-run aborts immediately and asynchronously. No partial counts survive.

## Configuration
- Macro: `SCB_MISMATCH_LOG_EN`.
- Defined: adds the following output ports.
  - `miss_valid` 1, sticky.
  - `miss_idx` CNT_W, pair index k.
  - `miss_word` 44, packed observed `{res,3'd0,z,3'd0,c,3'd0,v}`.
  - These capture the first pair in the run with any result, flag or select mismatch. Later mismatches do not overwrite it. The log is cleared by `start` and by reset (reset value 0).
- Undefined: these ports and their registers are absent; all other behaviour is identical.

## Test plan
- Reset: assert `rst_n`=0 with random inputs -> all outputs 0; `obs_ready`/`exp_ready` stay 0 until `start`.
- Clean run: `start`, then 75 matching pairs back-to-back -> `done` two edges after the last acceptance; op counters read 15; z/c/v read 75; `all_pass`=1; `seq_err`=0.
- Result miss: pair 20 (sub phase) has `obs_res` off by 1 -> sub=14, z/c/v=75, `all_pass`=0. With log: `miss_idx`=20 and `miss_word` equals the observed word.
- Flag miss: `obs_c` inverted on all 15 add pairs -> add=15, c=60, z=75, v=75, `all_pass`=0.
- Order error: pair 31 carries `obs_sel`=3'b011 instead of 3'b010 -> `seq_err`=1 from the next edge; and=14; or=15.
- Backpressure and abort:
  - Hold `obs_valid`=1 with `exp_valid` gapped 0 for 3 cycles -> no acceptance during the gaps; final counts unaffected.
  - Pulse `start` mid-run -> ignored.
  - Drop `rst_n` at pair 40 -> immediate IDLE with all counters 0.
